// File: rtl/edge_pipe_seq.sv
// Frame sequencer for the edge-detector pipeline: runs each kernel in turn, re-arms it with
// a one-cycle local reset, and ping-pongs the two frame buffers. Optional timeout: EDGE_SEQ_TIMEOUT_EN.
module edge_pipe_seq #(
    parameter int NUM_STAGES  = 4,
    parameter int STG_BITS    = 2,
    parameter int TIMEOUT_CYC = 65536,
    parameter int TO_BITS     = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  frame_done,
    output logic [NUM_STAGES-1:0] stage_run,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic [STG_BITS-1:0]   cur_stage,
    output logic                  src_buf_sel,
    output logic                  dst_buf_sel,
    output logic                  result_buf,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RUN, S_NEXT, S_FIN, S_ABRT
    } state_t;

    localparam logic [STG_BITS-1:0] LAST_STG = STG_BITS'(NUM_STAGES - 1);

    state_t                r_state;
    state_t                w_nxt;
    logic [STG_BITS-1:0]   r_cur_stage;
    logic                  r_src;
    logic                  r_result;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [NUM_STAGES-1:0] w_sel_oh;
    logic                  w_done;
    logic                  w_last;
    logic                  w_timeout;

    // Stage select decode from registers only, so run/reset outputs have no input paths.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        assign w_sel_oh[k]    = (r_cur_stage == STG_BITS'(k));
        assign stage_run[k]   = (r_state == S_RUN) && w_sel_oh[k];
        assign stage_rst_n[k] = !((r_state == S_ARM) || (r_state == S_ABRT) ||
                                  ((r_state == S_NEXT) && w_sel_oh[k]));
    end

    assign w_done = |(stage_done & w_sel_oh);
    assign w_last = (r_cur_stage == LAST_STG);

`ifdef EDGE_SEQ_TIMEOUT_EN
    logic [TO_BITS-1:0] r_to_cnt;
    logic               r_err;

    assign w_timeout = (r_state == S_RUN) && !w_done &&
                       (r_to_cnt == TO_BITS'(TIMEOUT_CYC - 1));

    // Held at zero outside RUN, so it is clear on the first cycle of every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != S_RUN) r_to_cnt <= '0;
            else                  r_to_cnt <= r_to_cnt + TO_BITS'(1);
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_to_cfg;
    assign w_unused_to_cfg = (TIMEOUT_CYC > 0) && (TO_BITS > 0);
    assign w_timeout       = 1'b0;
    assign err             = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // abort outranks stage_done and start in every active state.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_nxt = S_ARM;
            S_ARM:  w_nxt = abort ? S_ABRT : S_RUN;
            S_RUN: begin
                if (abort || w_timeout) w_nxt = S_ABRT;
                else if (w_done)        w_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (abort)       w_nxt = S_ABRT;
                else if (w_last) w_nxt = S_FIN;
                else             w_nxt = S_RUN;
            end
            S_FIN:   w_nxt = abort ? S_ABRT : S_IDLE;
            S_ABRT:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_stage  <= '0;
            r_src        <= 1'b0;
            r_result     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_busy       <= (w_nxt != S_IDLE);
            r_frame_done <= (w_nxt == S_FIN);
            if ((w_nxt == S_ARM) || (w_nxt == S_ABRT) ||
                ((r_state == S_FIN) && (w_nxt == S_IDLE))) begin
                r_cur_stage <= '0;
                r_src       <= 1'b0;
            end else if ((r_state == S_NEXT) && (w_nxt == S_RUN)) begin
                r_cur_stage <= r_cur_stage + STG_BITS'(1);
                r_src       <= ~r_src;
            end
            // Last stage wrote the buffer opposite the one it read.
            if ((r_state == S_NEXT) && (w_nxt == S_FIN)) r_result <= ~r_src;
        end
    end

    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign cur_stage   = r_cur_stage;
    assign src_buf_sel = r_src;
    assign dst_buf_sel = ~r_src;
    assign result_buf  = r_result;

endmodule

// File: tb/tb_edge_pipe_seq.sv
// Directed bench for edge_pipe_seq: 4 stub kernels on a 4x3 image (12 run cycles per stage).
module tb_edge_pipe_seq;

    localparam int NS = 4;
    localparam int SB = 2;
    localparam int P  = 12;
`ifdef EDGE_SEQ_TIMEOUT_EN
    localparam int TOC = 20;
`else
    localparam int TOC = 65536;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          stall1 = 1'b0;
    logic          busy, frame_done, src_buf_sel, dst_buf_sel, result_buf, err;
    logic [NS-1:0] stage_run, stage_done, stage_rst_n;
    logic [SB-1:0] cur_stage;
    logic [NS-1:0][7:0] cnt_w;

    int checks = 0;
    int failures = 0;

    edge_pipe_seq #(.NUM_STAGES(NS), .STG_BITS(SB), .TIMEOUT_CYC(TOC), .TO_BITS(17)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .frame_done(frame_done), .stage_run(stage_run),
        .stage_done(stage_done), .stage_rst_n(stage_rst_n), .cur_stage(cur_stage),
        .src_buf_sel(src_buf_sel), .dst_buf_sel(dst_buf_sel),
        .result_buf(result_buf), .err(err)
    );

    always #5 clk = ~clk;

    // Stub kernels: pixel counter cleared only by its own (ANDed) reset, done on last pixel.
    for (genvar k = 0; k < NS; k++) begin : g_stub
        logic       krst;
        logic [7:0] c;
        assign krst = rst_n & stage_rst_n[k];
        always_ff @(posedge clk or negedge krst) begin
            if (!krst)             c <= '0;
            else if (stage_run[k]) c <= c + 8'd1;
        end
        assign cnt_w[k]      = c;
        assign stage_done[k] = stage_run[k] && (c == 8'(P - 1)) && ((k == 1) ? !stall1 : 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        step();
    endtask

    // Checks one full frame, cycle 1 (ARM) through cycle 55 (IDLE).
    task automatic check_frame(input bit hold);
        logic [NS-1:0] one, e_run, e_rst;
        logic [SB-1:0] e_cur;
        logic e_src, e_busy, e_fd;
        int off, k, p;
        one = 1;
        kick();
        for (int c = 1; c <= 55; c++) begin
            if (c == 1 && !hold) start = 1'b0;
            e_run = '0; e_rst = '1; e_cur = '0; e_src = 1'b0;
            e_busy = (c <= 54); e_fd = (c == 54);
            if (c == 1) e_rst = '0;
            else if (c >= 2 && c <= 53) begin
                off = c - 2; k = off / 13; p = off % 13;
                e_cur = SB'(k); e_src = k[0];
                if (p < P) e_run = one << k;
                else       e_rst = ~(one << k);
            end else if (c == 54) begin
                e_cur = 2'd3; e_src = 1'b1;
            end
            checks += 8;
            if (stage_run !== e_run) begin failures++; $display("FAIL frame_run cyc=%0d got=%b exp=%b", c, stage_run, e_run); end
            if (stage_rst_n !== e_rst) begin failures++; $display("FAIL frame_rst cyc=%0d got=%b exp=%b", c, stage_rst_n, e_rst); end
            if (cur_stage !== e_cur) begin failures++; $display("FAIL frame_cur cyc=%0d got=%0d exp=%0d", c, cur_stage, e_cur); end
            if (src_buf_sel !== e_src) begin failures++; $display("FAIL frame_src cyc=%0d got=%b exp=%b", c, src_buf_sel, e_src); end
            if (dst_buf_sel !== ~e_src) begin failures++; $display("FAIL frame_dst cyc=%0d got=%b exp=%b", c, dst_buf_sel, ~e_src); end
            if (busy !== e_busy) begin failures++; $display("FAIL frame_busy cyc=%0d got=%b exp=%b", c, busy, e_busy); end
            if (frame_done !== e_fd) begin failures++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", c, frame_done, e_fd); end
            if (result_buf !== 1'b0) begin failures++; $display("FAIL frame_result cyc=%0d got=%b exp=0", c, result_buf); end
            if (c < 55) step();
        end
        checks += 2;
        if (cnt_w !== '0) begin failures++; $display("FAIL frame_stub_cnt got=%h exp=0", cnt_w); end
        if (err !== 1'b0) begin failures++; $display("FAIL frame_err got=%b exp=0", err); end
    endtask

    task automatic test_reset();
        #3;
        checks += 9;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_fd got=%b exp=0", frame_done); end
        if (stage_run !== '0) begin failures++; $display("FAIL rst_run got=%b exp=0000", stage_run); end
        if (stage_rst_n !== '1) begin failures++; $display("FAIL rst_rstn got=%b exp=1111", stage_rst_n); end
        if (cur_stage !== '0) begin failures++; $display("FAIL rst_cur got=%0d exp=0", cur_stage); end
        if (src_buf_sel !== 1'b0) begin failures++; $display("FAIL rst_src got=%b exp=0", src_buf_sel); end
        if (dst_buf_sel !== 1'b1) begin failures++; $display("FAIL rst_dst got=%b exp=1", dst_buf_sel); end
        if (result_buf !== 1'b0) begin failures++; $display("FAIL rst_result got=%b exp=0", result_buf); end
        if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_start_held();
        check_frame(1'b1);
        step();
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("FAIL held_rearm_busy got=%b exp=1", busy); end
        if (stage_rst_n !== '0) begin failures++; $display("FAIL held_rearm_rst got=%b exp=0000", stage_rst_n); end
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        checks += 1;
        if (busy !== 1'b0) begin failures++; $display("FAIL held_cleanup_busy got=%b exp=0", busy); end
    endtask

    task automatic test_abort();
        bit seen_fd;
        seen_fd = 1'b0;
        kick();
        for (int c = 1; c <= 35; c++) begin
            if (c == 1) start = 1'b0;
            if (frame_done) seen_fd = 1'b1;
            if (c == 33) begin
                checks += 1;
                if (stage_run !== 4'b0100) begin failures++; $display("FAIL abort_pre_run got=%b exp=0100", stage_run); end
                abort = 1'b1;
            end
            if (c == 34) begin
                abort = 1'b0;
                checks += 3;
                if (stage_run !== '0) begin failures++; $display("FAIL abort_run got=%b exp=0000", stage_run); end
                if (stage_rst_n !== '0) begin failures++; $display("FAIL abort_rst got=%b exp=0000", stage_rst_n); end
                if (frame_done !== 1'b0) begin failures++; $display("FAIL abort_fd got=%b exp=0", frame_done); end
            end
            if (c < 35) step();
        end
        checks += 6;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle_busy got=%b exp=0", busy); end
        if (stage_rst_n !== '1) begin failures++; $display("FAIL abort_idle_rst got=%b exp=1111", stage_rst_n); end
        if (cur_stage !== '0) begin failures++; $display("FAIL abort_idle_cur got=%0d exp=0", cur_stage); end
        if (result_buf !== 1'b0) begin failures++; $display("FAIL abort_result got=%b exp=0", result_buf); end
        if (seen_fd !== 1'b0) begin failures++; $display("FAIL abort_no_fd got=%b exp=0", seen_fd); end
        if (cnt_w !== '0) begin failures++; $display("FAIL abort_stub_cnt got=%h exp=0", cnt_w); end
    endtask

`ifdef EDGE_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        stall1 = 1'b1;
        kick();
        for (int c = 1; c <= 36; c++) begin
            if (c == 1) start = 1'b0;
            if (c == 34) begin
                checks += 2;
                if (err !== 1'b0) begin failures++; $display("FAIL to_err_early got=%b exp=0", err); end
                if (stage_run !== 4'b0010) begin failures++; $display("FAIL to_run got=%b exp=0010", stage_run); end
            end
            if (c == 35) begin
                checks += 4;
                if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err); end
                if (stage_run !== '0) begin failures++; $display("FAIL to_abrt_run got=%b exp=0000", stage_run); end
                if (stage_rst_n !== '0) begin failures++; $display("FAIL to_abrt_rst got=%b exp=0000", stage_rst_n); end
                if (frame_done !== 1'b0) begin failures++; $display("FAIL to_fd got=%b exp=0", frame_done); end
            end
            if (c < 36) step();
        end
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL to_idle_busy got=%b exp=0", busy); end
        if (err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", err); end
        stall1 = 1'b0;
    endtask
`else
    task automatic test_stall();
        stall1 = 1'b1;
        kick();
        for (int c = 1; c <= 120; c++) begin
            if (c == 1) start = 1'b0;
            if (c < 120) step();
        end
        checks += 4;
        if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy); end
        if (stage_run !== 4'b0010) begin failures++; $display("FAIL stall_run got=%b exp=0010", stage_run); end
        if (cur_stage !== 2'd1) begin failures++; $display("FAIL stall_cur got=%0d exp=1", cur_stage); end
        if (err !== 1'b0) begin failures++; $display("FAIL stall_err got=%b exp=0", err); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        checks += 1;
        if (busy !== 1'b0) begin failures++; $display("FAIL stall_abort_busy got=%b exp=0", busy); end
        stall1 = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        kick();
        start = 1'b0;
        for (int c = 2; c <= 20; c++) step();
        checks += 1;
        if (stage_run !== 4'b0010) begin failures++; $display("FAIL arst_pre_run got=%b exp=0010", stage_run); end
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
        if (stage_run !== '0) begin failures++; $display("FAIL arst_run got=%b exp=0000", stage_run); end
        if (stage_rst_n !== '1) begin failures++; $display("FAIL arst_rstn got=%b exp=1111", stage_rst_n); end
        if (cur_stage !== '0) begin failures++; $display("FAIL arst_cur got=%0d exp=0", cur_stage); end
        if (src_buf_sel !== 1'b0) begin failures++; $display("FAIL arst_src got=%b exp=0", src_buf_sel); end
        if (err !== 1'b0) begin failures++; $display("FAIL arst_err got=%b exp=0", err); end
        if (cnt_w !== '0) begin failures++; $display("FAIL arst_stub_cnt got=%h exp=0", cnt_w); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_frame(1'b0);
    endtask

    initial begin
        test_reset();
        check_frame(1'b0);
        check_frame(1'b0);
        test_start_held();
        test_abort();
`ifdef EDGE_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_pipe_seq.md
Name: edge_pipe_seq

Overview:
Frame-level sequencer for the edge-detector pipeline. Runs N raster kernels one after another: blur, gradient, edge thin, threshold. Each kernel has a run/done interface and a free-running pixel counter that only clears on its own reset. The block issues run to one stage at a time and re-arms each stage with a one-cycle local reset after it finishes. It also ping-pongs the two intermediate frame buffers between stages and reports frame completion to the top level.

Parameters:
NUM_STAGES, 4, number of kernels sequenced (>=1)
STG_BITS, 2, width of stage index (>= clog2(NUM_STAGES), min 1)
TIMEOUT_CYC, 65536, max cycles a stage may hold run before error (EDGE_SEQ_TIMEOUT_EN only)
TO_BITS, 17, timeout counter width (>= clog2(TIMEOUT_CYC+1))

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  begin one frame; sampled only in IDLE
abort  in  1  abandon current frame; all stages re-armed
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse, last stage finished
stage_run  out  NUM_STAGES  one-hot run to kernels (all zero when none)
stage_done  in  NUM_STAGES  kernel done flags (combinational in kernel)
stage_rst_n  out  NUM_STAGES  per-kernel active-low reset, ANDed with rst_n at top level
cur_stage  out  STG_BITS  index of active stage
src_buf_sel  out  1  frame buffer read by active stage
dst_buf_sel  out  1  frame buffer written by active stage; always ~src_buf_sel
result_buf  out  1  buffer holding final result of last completed frame
err  out  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Reset values: state=IDLE, busy=0, frame_done=0, stage_run=0, stage_rst_n=all 1, cur_stage=0, src_buf_sel=0, dst_buf_sel=1, result_buf=0, err=0.
- States: IDLE, ARM, RUN, NEXT, FIN.
- IDLE: busy=0. start=1 -> ARM. start in any other state is ignored; no queuing.
- ARM (1 cycle):
  - stage_rst_n = all 0; cur_stage=0; src_buf_sel=0; busy=1.
  - Next state RUN.
- RUN:
  - stage_run[cur_stage]=1, all other bits 0.
  - Stage counters advance on each run cycle; stage_done[cur_stage] is high on the cycle the last pixel is written. That cycle keeps run=1 so the last write happens.
  - If stage_done[cur_stage]=1 -> NEXT. The stage therefore sees exactly W*H run cycles.
  - stage_done bits of inactive stages are ignored.
- NEXT (1 cycle):
  - stage_run=0; stage_rst_n[cur_stage]=0, all other bits 1.
  - If cur_stage==NUM_STAGES-1: result_buf<=dst_buf_sel, then -> FIN.
  - Otherwise: cur_stage<=cur_stage+1, src_buf_sel toggles (dst follows), then -> RUN.
- FIN (1 cycle): frame_done=1, busy=1; next IDLE with cur_stage<=0, src_buf_sel<=0.
- Latency: start sampled at edge 0. ARM at cycle 1, first run at cycle 2. frame_done is high at cycle 2+NUM_STAGES*(P+1), where P=W*H. busy falls the following cycle.
- Buffer rule: stage k reads buffer (k mod 2) and writes buffer ((k+1) mod 2). The top level loads the source image into buffer 0.
- abort=1 in ARM/RUN/NEXT/FIN -> ARM-like clear cycle:
  - stage_run=0 and stage_rst_n all 0 for 1 cycle, then IDLE.
  - No frame_done; result_buf unchanged.
  - abort in IDLE has no effect. abort has priority over stage_done and start.
- rst_n assertion mid-frame returns every register to its reset value immediately. stage_rst_n is all 1 from the block itself; the top-level AND resets the kernels.
- Outputs are registered except stage_run and stage_rst_n, which are decoded from the state and cur_stage registers (glitch-free decode, no input paths).

Optional Feature:
Macro EDGE_SEQ_TIMEOUT_EN.
- Defined:
  - TO_BITS counter clears on entering RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC without stage_done: err<=1 (sticky until rst_n), then the abort sequence runs.
- Undefined: no counter; err tied 0; RUN waits indefinitely.

Test Plan:
- NUM_STAGES=4, stub kernels with 4x3 image (P=12), start pulse at cycle 0:
  - each stage_run bit high exactly 12 consecutive cycles, in order 0..3;
  - src_buf_sel sequence 0,1,0,1;
  - frame_done at cycle 54, result_buf=0;
  - busy low at cycle 55.
- After each stage completes -> that stage_rst_n low exactly 1 cycle (in NEXT); stub counter back at 0; a second start yields an identical 54-cycle frame.
- Start held high throughout frame -> ignored while busy; new frame begins 2 cycles after frame_done (IDLE then ARM).
- abort asserted in RUN of stage 2, pixel 5 -> next cycle all stage_rst_n low and stage_run=0, then IDLE; no frame_done; result_buf unchanged.
- rst_n pulsed low during stage 1 -> all outputs return to reset values asynchronously; start afterwards runs a clean frame.
- EDGE_SEQ_TIMEOUT_EN, TIMEOUT_CYC=20, stage 1 stub never asserts done -> err=1 after 20 run cycles; abort sequence runs, then IDLE with err still 1.
